// File: rtl/text_console_writer_if.sv
// Byte-stream handshake into the text console writer.
// Source drives valid/data, the writer answers with ready.
interface text_console_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns an ASCII stream into glyph writes
// for the character screen buffer, with cursor, wrap and clears.
module text_console_writer #(
  parameter int CHAR_COLUMNS = 60,
  parameter int CHAR_ROWS    = 17,
  parameter int ADDR_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  text_console_writer_if.slave  in_if,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [6:0]            wr_data,
  output logic [6:0]            cursor_x,
  output logic [4:0]            cursor_y,
  output logic                  busy
);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_e;

  localparam addr_t      COLS_A   = addr_t'(CHAR_COLUMNS);
  localparam addr_t      LAST_A   = addr_t'(CHAR_COLUMNS*CHAR_ROWS-1);
  localparam logic [6:0] LAST_COL = 7'(CHAR_COLUMNS-1);
  localparam logic [4:0] LAST_ROW = 5'(CHAR_ROWS-1);

  function automatic addr_t row_base(input logic [4:0] y);
    return addr_t'(y) * COLS_A;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  addr_t      clr_addr_q, clr_addr_d;
  addr_t      clr_end_q, clr_end_d;
  logic       clr_done_q, clr_done_d;
  logic       wr_en_q, wr_en_d;
  addr_t      wr_addr_q, wr_addr_d;
  logic [6:0] wr_data_q, wr_data_d;

  logic       accept;
  logic       is_prn, is_lf, is_cr, is_bs, is_ff;
  logic       adv;
  logic [4:0] ny;

  assign accept = in_if.in_valid && (state_q == IDLE);
  assign is_prn = (in_if.in_data >= 8'h20) && (in_if.in_data <= 8'h7E);
  assign is_lf  = (in_if.in_data == 8'h0A);
  assign is_cr  = (in_if.in_data == 8'h0D);
  assign is_bs  = (in_if.in_data == 8'h08);
  assign is_ff  = (in_if.in_data == 8'h0C);

  // Next-state: byte decode in IDLE, sequential zero fill in the clears.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    clr_addr_d = clr_addr_q;
    clr_end_d  = clr_end_q;
    clr_done_d = clr_done_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    adv        = 1'b0;
    ny         = cy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_prn: begin
              wr_en_d   = 1'b1;
              wr_addr_d = row_base(cy_q) + addr_t'(cx_q);
              wr_data_d = 7'(in_if.in_data - 8'h20);
              if (cx_q == LAST_COL) begin
                cx_d = 7'd0;
                adv  = 1'b1;
              end else begin
                cx_d = cx_q + 7'd1;
              end
            end
            is_lf: begin
              cx_d = 7'd0;
              adv  = 1'b1;
            end
            is_cr: cx_d = 7'd0;
            is_bs: begin
              if (cx_q != 7'd0) begin
                cx_d      = cx_q - 7'd1;
                wr_en_d   = 1'b1;
                wr_addr_d = row_base(cy_q) + addr_t'(cx_q - 7'd1);
                wr_data_d = 7'd0;
              end
            end
            is_ff: begin
              cx_d       = 7'd0;
              cy_d       = 5'd0;
              state_d    = CLEAR_ALL;
              clr_addr_d = '0;
              clr_end_d  = LAST_A;
              clr_done_d = 1'b0;
            end
            default: ;
          endcase
          if (adv) begin
            ny         = (cy_q == LAST_ROW) ? 5'd0 : cy_q + 5'd1;
            cy_d       = ny;
            state_d    = CLEAR_ROW;
            clr_addr_d = row_base(ny);
            clr_end_d  = row_base(ny) + COLS_A - addr_t'(1);
            clr_done_d = 1'b0;
          end
        end
      end
      CLEAR_ALL, CLEAR_ROW: begin
        if (clr_done_q) begin
          state_d    = IDLE;
          clr_done_d = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_addr_q;
          wr_data_d = 7'd0;
          if (clr_addr_q == clr_end_q) begin
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + addr_t'(1);
          end
        end
      end
      default: state_d = CLEAR_ALL;
    endcase
  end

  // State register; reset restarts a full-screen clear from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ALL;
      cx_q       <= 7'd0;
      cy_q       <= 5'd0;
      clr_addr_q <= '0;
      clr_end_q  <= LAST_A;
      clr_done_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 7'd0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      clr_addr_q <= clr_addr_d;
      clr_end_q  <= clr_end_d;
      clr_done_q <= clr_done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign cursor_x       = cx_q;
  assign cursor_y       = cy_q;

endmodule
